// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub
// Description : Parametrised add/subtract unit. The carry chain is cut into
//               STAGES equal segments, one segment resolved per clock, with a
//               global-advance valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Each stage carries the whole operand pair plus the partially built sum;
  // only segment k of the sum is written by stage k.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ov_q, ov_d;
  logic              adv;

  assign adv      = ~vld_q[LAST] | out_ready;
  assign in_ready = adv;

  always_comb begin : p_next
    logic [WIDTH-1:0] src_a, src_b, src_sum;
    logic             src_vld, src_cy;
    logic [SEG:0]     seg;
    int               prv;

    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_vld = 1'b0;
    src_cy  = 1'b0;
    seg     = '0;
    prv     = 0;
    vld_d   = vld_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ov_d    = ov_q;

    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        prv = (k > 0) ? k - 1 : 0;
        if (k == 0) begin
          // Bubbles enter as all-zero operands so idle slots present Sum=0.
          src_vld = in_valid;
          src_a   = in_valid ? A : '0;
          src_b   = in_valid ? (Sub ? ~B : B) : '0;
          src_cy  = in_valid & (Sub | Cin);
          src_sum = '0;
        end else begin
          src_vld = vld_q[prv];
          src_a   = a_q[prv];
          src_b   = b_q[prv];
          src_cy  = cy_q[prv];
          src_sum = sum_q[prv];
        end
        seg = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
            + {{SEG{1'b0}}, src_cy};
        src_sum[k*SEG +: SEG] = seg[SEG-1:0];
        vld_d[k] = src_vld;
        a_d[k]   = src_a;
        b_d[k]   = src_b;
        sum_d[k] = src_sum;
        cy_d[k]  = seg[SEG];
      end
      // Same-sign operands giving an opposite-sign result is exactly
      // carry-into-MSB XOR carry-out-of-MSB.
      ov_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
             (sum_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ov_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ov_q  <= ov_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign Sum       = sum_q[LAST];
  assign Cout      = cy_q[LAST];
  assign Overflow  = ov_q;
  assign out_valid = vld_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_addsub
// Description : Directed bench for pipelined_addsub at STAGES = 4, 1 and 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0, Sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;

  logic        in_ready4, in_ready1, in_ready16;
  logic [15:0] sum4, sum1, sum16;
  logic        cout4, cout1, cout16;
  logic        ov4, ov1, ov16;
  logic        vld4, vld1, vld16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(in_ready4), .Sum(sum4), .Cout(cout4),
    .Overflow(ov4), .out_valid(vld4), .out_ready(out_ready));

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(in_ready1), .Sum(sum1), .Cout(cout1),
    .Overflow(ov1), .out_valid(vld1), .out_ready(out_ready));

  pipelined_addsub #(.WIDTH(16), .STAGES(16)) u16 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(in_ready16), .Sum(sum16), .Cout(cout16),
    .Overflow(ov16), .out_valid(vld16), .out_ready(out_ready));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ov;
  } vec_t;

  vec_t vecs [9];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] r;
    logic        ov;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {16'd0, (sub | cin)};
    ov = (a[15] == be[15]) && (r[15] != a[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  task automatic chk_dut(input string nm, input int s, input int j, input vec_t v,
                         input logic vld, input logic [15:0] sm, input logic c,
                         input logic o);
    if (j == s - 1) begin
      cmp({nm, "_valid"}, 32'(vld), 32'd1);
      cmp({nm, "_sum"}, 32'(sm), 32'(v.sum));
      cmp({nm, "_cout"}, 32'(c), 32'(v.cout));
      cmp({nm, "_ov"}, 32'(o), 32'(v.ov));
    end else begin
      cmp({nm, "_novalid"}, 32'(vld), 32'd0);
    end
  endtask

  // One op into empty pipes; each instance must present it exactly STAGES cycles later.
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    A = v.a; B = v.b; Cin = v.cin; Sub = v.sub; in_valid = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk_dut({nm, "_s4"}, 4, j, v, vld4, sum4, cout4, ov4);
      chk_dut({nm, "_s1"}, 1, j, v, vld1, sum1, cout1, ov1);
      chk_dut({nm, "_s16"}, 16, j, v, vld16, sum16, cout16, ov16);
    end
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    cmp("rst_valid", 32'(vld4), 32'd0);
    cmp("rst_sum", 32'(sum4), 32'd0);
    cmp("rst_cout", 32'(cout4), 32'd0);
    cmp("rst_ov", 32'(ov4), 32'd0);
    cmp("rst_in_ready", 32'(in_ready4), 32'd1);
    cmp("rst_valid_s16", 32'(vld16), 32'd0);
    rst = 1'b0;

    // Directed vectors on all three depths
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back random ops with random consumer stalls on the 4-stage unit
    begin : t_stream
      logic [17:0] q[$];
      logic [17:0] exp;
      int          sent, got, cyc;
      logic        stall_prev;
      logic [15:0] ps;
      logic        pc, po;
      sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; ps = '0; pc = 1'b0; po = 1'b0;
      while (got < 8 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        out_ready = 1'($urandom_range(0, 1));
        if (sent < 8) begin
          in_valid = 1'b1;
          A   = 16'($urandom);
          B   = 16'($urandom);
          Cin = 1'($urandom_range(0, 1));
          Sub = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
        #1;
        cmp("strm_in_ready", 32'(in_ready4), 32'(!(vld4 && !out_ready)));
        if (stall_prev) begin
          cmp("strm_hold_valid", 32'(vld4), 32'd1);
          cmp("strm_hold_sum", 32'(sum4), 32'(ps));
          cmp("strm_hold_cout", 32'(cout4), 32'(pc));
          cmp("strm_hold_ov", 32'(ov4), 32'(po));
        end
        if (in_valid && in_ready4) begin
          q.push_back(model(A, B, Cin, Sub));
          sent++;
        end
        if (vld4 && out_ready) begin
          if (q.size() == 0) begin
            cmp("strm_unexpected_out", 32'd1, 32'd0);
          end else begin
            exp = q.pop_front();
            cmp("strm_result", {14'd0, ov4, cout4, sum4}, {14'd0, exp});
          end
          got++;
        end
        stall_prev = vld4 && !out_ready;
        ps = sum4; pc = cout4; po = ov4;
      end
      cmp("strm_all_retired", 32'(got), 32'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end

    // Reset with three ops in flight
    @(negedge clk);
    A = 16'h0001; B = 16'h0002; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    A = 16'h0003;
    @(negedge clk);
    A = 16'h0005;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    cmp("mid_rst_valid", 32'(vld4), 32'd0);
    cmp("mid_rst_sum", 32'(sum4), 32'd0);
    @(negedge clk);
    cmp("mid_rst_valid2", 32'(vld4), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      cmp("post_rst_valid", 32'(vld4), 32'd0);
      cmp("post_rst_sum", 32'(sum4), 32'd0);
    end
    run_vec('{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
